// File: rtl/remote_snd.sv
// NEC infrared transmitter with an Avalon-MM slave interface.
// Produces a 38 kHz-modulated LED drive and a baseband copy of each frame or repeat code.
module remote_snd #(
  parameter int unsigned SLOT_CYC    = 56250,
  parameter int unsigned CARRIER_DIV = 2632,
  parameter int unsigned GAP_SLOTS   = 16
) (
  input  logic        clk_100m,
  input  logic        sys_rst_n,
  input  logic [2:0]  avl_address,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic        avl_read,
  output logic [31:0] avl_readdata,
  output logic        ir_led,
  output logic        ir_base,
  output logic        tx_busy
);

  localparam int unsigned SLOT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int unsigned CAR_W     = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int unsigned CAR_HALF  = CARRIER_DIV / 2;
  localparam int unsigned MAX_SLOTS = (GAP_SLOTS > 16) ? GAP_SLOTS : 16;
  localparam int unsigned NUM_W     = $clog2(MAX_SLOTS + 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_SPACE, STOP_MARK, GAP
  } state_t;

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [NUM_W-1:0]  slot_num;
  logic [NUM_W-1:0]  slot_last_c;
  logic [CAR_W-1:0]  car_cnt, car_nxt_c;
  logic [31:0]       shreg;
  logic [4:0]        bit_cnt;
  logic              is_rep;
  logic              err;
  logic              slot_end_c, state_done_c;
  logic              start_wr_c, accept_c;
  logic              mark_cur_c, mark_nxt_c;
  logic              unused_wdata;

  assign unused_wdata = ^avl_writedata[31:16];

  // Last slot index of the current state and the resulting next state.
  always_comb begin
    slot_last_c = '0;
    state_nxt   = state;
    slot_end_c  = (slot_cnt == SLOT_W'(SLOT_CYC - 1));
    start_wr_c  = avl_write && (avl_address == 3'd0 || avl_address == 3'd1);
    accept_c    = start_wr_c && (state == IDLE);

    case (state)
      LEAD_MARK:  slot_last_c = NUM_W'(15);
      LEAD_SPACE: slot_last_c = NUM_W'(7);
      BIT_SPACE:  slot_last_c = shreg[0] ? NUM_W'(2) : NUM_W'(0);
      REP_SPACE:  slot_last_c = NUM_W'(3);
      GAP:        slot_last_c = NUM_W'(GAP_SLOTS - 1);
      default:    slot_last_c = '0;
    endcase

    state_done_c = slot_end_c && (slot_num == slot_last_c);

    case (state)
      IDLE:       if (accept_c)     state_nxt = LEAD_MARK;
      LEAD_MARK:  if (state_done_c) state_nxt = is_rep ? REP_SPACE : LEAD_SPACE;
      LEAD_SPACE: if (state_done_c) state_nxt = BIT_MARK;
      BIT_MARK:   if (state_done_c) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (state_done_c) state_nxt = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
      REP_SPACE:  if (state_done_c) state_nxt = STOP_MARK;
      STOP_MARK:  if (state_done_c) state_nxt = GAP;
      GAP:        if (state_done_c) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase

    mark_cur_c = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    mark_nxt_c = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
                 (state_nxt == STOP_MARK);
    car_nxt_c  = (car_cnt == CAR_W'(CARRIER_DIV - 1)) ? '0 : car_cnt + CAR_W'(1);
  end

  // State, slot timing, shift register and registered outputs.
  always_ff @(posedge clk_100m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      slot_num     <= '0;
      car_cnt      <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      is_rep       <= 1'b0;
      err          <= 1'b0;
      ir_led       <= 1'b0;
      ir_base      <= 1'b1;
      tx_busy      <= 1'b0;
      avl_readdata <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) begin
        slot_cnt <= '0;
        slot_num <= '0;
      end else if (state != IDLE) begin
        if (slot_end_c) begin
          slot_cnt <= '0;
          slot_num <= slot_num + NUM_W'(1);
        end else begin
          slot_cnt <= slot_cnt + SLOT_W'(1);
        end
      end

      if (accept_c) begin
        shreg   <= {~avl_writedata[7:0], avl_writedata[7:0],
                    ~avl_writedata[15:8], avl_writedata[15:8]};
        is_rep  <= (avl_address == 3'd1);
        bit_cnt <= '0;
      end else if (state == BIT_SPACE && state_done_c) begin
        shreg   <= {1'b0, shreg[31:1]};
        bit_cnt <= bit_cnt + 5'd1;
      end

      // Carrier phase restarts with every mark so each mark begins high.
      if (mark_nxt_c && !mark_cur_c) begin
        car_cnt <= '0;
        ir_led  <= (CAR_HALF > 0);
      end else if (mark_nxt_c) begin
        car_cnt <= car_nxt_c;
        ir_led  <= (car_nxt_c < CAR_W'(CAR_HALF));
      end else begin
        car_cnt <= '0;
        ir_led  <= 1'b0;
      end

      ir_base <= ~mark_nxt_c;
      tx_busy <= (state_nxt != IDLE);

      if (start_wr_c && state != IDLE) begin
        err <= 1'b1;
      end else if (avl_write && avl_address == 3'd2) begin
        err <= 1'b0;
      end

      if (avl_read) begin
        avl_readdata <= (avl_address == 3'd2) ? {30'd0, err, tx_busy} : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_remote_snd.sv
// Directed bench for remote_snd with shortened slot and carrier timing.
// Decodes the baseband waveform by pulse width and checks carrier shape in every mark.
module tb_remote_snd;

  localparam int unsigned SLOT = 10;
  localparam int unsigned CDIV = 6;
  localparam int unsigned GAPS = 3;
  localparam int          LIM  = 5000;

  logic        clk_100m = 1'b0;
  logic        sys_rst_n;
  logic [2:0]  avl_address;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic        avl_read;
  logic [31:0] avl_readdata;
  logic        ir_led;
  logic        ir_base;
  logic        tx_busy;

  int n_cmp = 0;
  int n_err = 0;

  remote_snd #(.SLOT_CYC(SLOT), .CARRIER_DIV(CDIV), .GAP_SLOTS(GAPS)) dut (
    .clk_100m      (clk_100m),
    .sys_rst_n     (sys_rst_n),
    .avl_address   (avl_address),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_read      (avl_read),
    .avl_readdata  (avl_readdata),
    .ir_led        (ir_led),
    .ir_base       (ir_base),
    .tx_busy       (tx_busy)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    avl_address   = a;
    avl_writedata = d;
    avl_write     = 1'b1;
    @(negedge clk_100m);
    avl_write     = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] q);
    avl_address = a;
    avl_read    = 1'b1;
    @(negedge clk_100m);
    avl_read    = 1'b0;
    q           = avl_readdata;
  endtask

  // Count samples while ir_base holds lvl; n starts at idx, led shape checked per sample.
  task automatic run_len(input logic lvl, input int idx, output int n, output int lerr);
    n    = idx;
    lerr = 0;
    while (ir_base === lvl && n < LIM) begin
      if (lvl == 1'b0) begin
        if (ir_led !== (((n % CDIV) < (CDIV / 2)) ? 1'b1 : 1'b0)) lerr++;
      end else if (ir_led !== 1'b0) begin
        lerr++;
      end
      n++;
      @(negedge clk_100m);
    end
  endtask

  task automatic measure_gap(output int g, output int gerr);
    g    = 0;
    gerr = 0;
    while (tx_busy === 1'b1 && g < LIM) begin
      if (ir_led !== 1'b0 || ir_base !== 1'b1) gerr++;
      g++;
      @(negedge clk_100m);
    end
  endtask

  // Entered at a negedge inside the leader mark with pre samples already elapsed.
  task automatic measure_frame(input string tag, input int pre, input logic [31:0] exp_word);
    int n, e, tot, bad, lerr;
    logic [31:0] word;
    run_len(1'b0, pre, n, e);
    check({tag, "_lead_mark"}, 32'(n), 32'd160);
    check({tag, "_lead_led"}, 32'(e), 32'd0);
    tot = n;
    run_len(1'b1, 0, n, e);
    check({tag, "_lead_space"}, 32'(n), 32'd80);
    tot += n;
    lerr = e;
    bad  = 0;
    word = '0;
    for (int i = 0; i < 32; i++) begin
      run_len(1'b0, 0, n, e);
      lerr += e;
      tot  += n;
      if (n != 10) bad++;
      run_len(1'b1, 0, n, e);
      lerr += e;
      tot  += n;
      if (n == 30)      word[i] = 1'b1;
      else if (n != 10) bad++;
    end
    check({tag, "_bit_widths"}, 32'(bad), 32'd0);
    check({tag, "_word"}, word, exp_word);
    run_len(1'b0, 0, n, e);
    lerr += e;
    check({tag, "_stop_mark"}, 32'(n), 32'd10);
    tot += n;
    measure_gap(n, e);
    check({tag, "_gap"}, 32'(n), 32'd30);
    tot += n;
    check({tag, "_led_shape"}, 32'(lerr + e), 32'd0);
    check({tag, "_busy_total"}, 32'(tot), 32'd1240);
    check({tag, "_idle_after"}, {29'd0, tx_busy, ir_base, ir_led}, 32'b010);
  endtask

  initial begin
    logic [31:0] q;
    int n, e, tot;

    // Reset values
    sys_rst_n     = 1'b0;
    avl_address   = '0;
    avl_write     = 1'b0;
    avl_writedata = '0;
    avl_read      = 1'b0;
    repeat (3) @(negedge clk_100m);
    check("rst_ir_base", 32'(ir_base), 32'd1);
    check("rst_ir_led", 32'(ir_led), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_readdata", avl_readdata, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk_100m);

    // Reset mid leader mark, with err set beforehand
    do_write(3'd0, 32'h0000_00AA);
    check("acc_busy", 32'(tx_busy), 32'd1);
    check("acc_base", 32'(ir_base), 32'd0);
    repeat (5) @(negedge clk_100m);
    do_write(3'd1, 32'h0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_outs", {29'd0, tx_busy, ir_base, ir_led}, 32'b010);
    @(negedge clk_100m);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk_100m);
    do_read(3'd2, q);
    check("rst_status", q, 32'd0);
    check("rst_no_resume", {29'd0, tx_busy, ir_base, ir_led}, 32'b010);

    // Frame 0x0000 and frame 0x0045
    do_write(3'd0, 32'h0000_0000);
    measure_frame("f0000", 0, 32'hFF00_FF00);
    repeat (3) @(negedge clk_100m);
    do_write(3'd0, 32'hFFFF_0045);
    measure_frame("f0045", 0, 32'hBA45_FF00);
    repeat (3) @(negedge clk_100m);

    // Repeat code
    do_write(3'd1, 32'h1234_5678);
    run_len(1'b0, 0, n, e);
    check("rep_lead_mark", 32'(n), 32'd160);
    tot = n;
    run_len(1'b1, 0, n, e);
    check("rep_space", 32'(n), 32'd40);
    tot += n;
    run_len(1'b0, 0, n, e);
    check("rep_stop_mark", 32'(n), 32'd10);
    tot += n;
    measure_gap(n, e);
    check("rep_gap", 32'(n), 32'd30);
    tot += n;
    check("rep_total", 32'(tot), 32'd240);
    repeat (3) @(negedge clk_100m);

    // Start while busy: frame unaffected, err sticky until cleared
    do_write(3'd0, 32'h0000_1234);
    do_write(3'd0, 32'h0000_ABCD);
    do_read(3'd2, q);
    check("busy_status", q, 32'd3);
    do_read(3'd5, q);
    check("other_addr_read", q, 32'd0);
    do_write(3'd2, 32'h0);
    measure_frame("f1234", 4, 32'hCB34_ED12);
    do_read(3'd2, q);
    check("cleared_status", q, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
